// File: rtl/alu_share_arbiter_if.sv
// Requester, response and ALU-side signals of the two-requester ALU arbiter.
// slave = the arbiter; master = requesters plus the attached ALU.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 32
) ();
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]       req0_ctrl, req1_ctrl;
  logic             rsp0_valid, rsp1_valid;
  logic             rsp0_ready, rsp1_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [3:0]       rsp_flags;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_out;
  logic [3:0]       alu_flags;
  logic             busy;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_ctrl, req1_ctrl, rsp0_ready, rsp1_ready, alu_out, alu_flags,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result,
           rsp_flags, alu_a, alu_b, alu_ctrl, busy
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_ctrl, req1_ctrl, rsp0_ready, rsp1_ready, alu_out, alu_flags,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result,
           rsp_flags, alu_a, alu_b, alu_ctrl, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters, one op in flight.
// Optional performance counters are built when ALU_ARB_PERF_EN is defined.
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_share_arbiter_if.slave  bus
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [15:0]         perf_grant0,
  output logic [15:0]         perf_grant1,
  output logic [15:0]         perf_stall
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           r_state, w_next_state;
  logic             r_owner, r_last_grant;
  logic             r_rsp0_valid, r_rsp1_valid;
  logic [WIDTH-1:0] r_alu_a, r_alu_b, r_rsp_result;
  logic [3:0]       r_alu_ctrl, r_rsp_flags;
  logic             w_win0, w_win1, w_accept0, w_accept1, w_rsp_take;

  // On a tie the requester that was not granted last wins.
  // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    w_win0       = bus.req0_valid && (!bus.req1_valid || r_last_grant);
    w_win1       = bus.req1_valid && (!bus.req0_valid || !r_last_grant);
    w_accept0    = (r_state == IDLE) && w_win0;
    w_accept1    = (r_state == IDLE) && w_win1;
    w_rsp_take   = r_owner ? bus.rsp1_ready : bus.rsp0_ready;
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept0 || w_accept1) w_next_state = EXEC;
      EXEC:    w_next_state = RESP;
      RESP:    if (w_rsp_take) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_ctrl   <= '0;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept0) begin
            r_alu_a      <= bus.req0_a;
            r_alu_b      <= bus.req0_b;
            r_alu_ctrl   <= bus.req0_ctrl;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b0;
          end else if (w_accept1) begin
            r_alu_a      <= bus.req1_a;
            r_alu_b      <= bus.req1_b;
            r_alu_ctrl   <= bus.req1_ctrl;
            r_owner      <= 1'b1;
            r_last_grant <= 1'b1;
          end
        end
        EXEC: begin
          r_rsp_result <= bus.alu_out;
          r_rsp_flags  <= bus.alu_flags;
          if (r_owner) r_rsp1_valid <= 1'b1;
          else         r_rsp0_valid <= 1'b1;
        end
        RESP: begin
          if (w_rsp_take) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req0_ready = w_accept0;
  assign bus.req1_ready = w_accept1;
  assign bus.rsp0_valid = r_rsp0_valid;
  assign bus.rsp1_valid = r_rsp1_valid;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_flags  = r_rsp_flags;
  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;
  assign bus.alu_ctrl   = r_alu_ctrl;
  assign bus.busy       = (r_state != IDLE);

`ifdef ALU_ARB_PERF_EN
  logic [15:0] r_perf_grant0, r_perf_grant1, r_perf_stall;
  logic        w_stall;

  assign w_stall = (bus.req0_valid && !w_accept0) || (bus.req1_valid && !w_accept1);

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_grant0 <= '0;
      r_perf_grant1 <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (w_accept0 && (r_perf_grant0 != 16'hFFFF)) r_perf_grant0 <= r_perf_grant0 + 16'd1;
      if (w_accept1 && (r_perf_grant1 != 16'hFFFF)) r_perf_grant1 <= r_perf_grant1 + 16'd1;
      if (w_stall   && (r_perf_stall  != 16'hFFFF)) r_perf_stall  <= r_perf_stall  + 16'd1;
    end
  end

  assign perf_grant0 = r_perf_grant0;
  assign perf_grant1 = r_perf_grant1;
  assign perf_stall  = r_perf_stall;
`endif

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares one combinational ALU (WIDTH-bit operands, 4-bit alu_ctrl, flags {zero,sign,carry,overflow}) between two requesters, e.g. the integer pipeline and an address/branch-compare unit.
- Round-robin arbitration with a valid/ready request handshake per requester.
- Registers the granted operands into the ALU.
- Captures result and flags, then returns them on a per-requester valid/ready response channel.
- One operation in flight at a time.

Parameters:
WIDTH, 32, operand/result width; must match the attached ALU.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid, req1_valid  input  1  request present
req0_ready, req1_ready  output  1  request accepted this cycle
req0_a, req0_b, req1_a, req1_b  input  WIDTH  operands
req0_ctrl, req1_ctrl  input  4  ALU opcode
rsp0_valid, rsp1_valid  output  1  response available
rsp0_ready, rsp1_ready  input  1  requester takes response
rsp_result  output  WIDTH  shared response data, meaningful only with rspN_valid
rsp_flags  output  4  {zero,sign,carry,overflow} of the op
alu_a, alu_b  output  WIDTH  to ALU a/b
alu_ctrl  output  4  to ALU alu_ctrl
alu_out  input  WIDTH  from ALU
alu_flags  input  4  from ALU flags
busy  output  1  state != IDLE

Behaviour:
- Reset (async assert, sync-safe release): state=IDLE, alu_a=alu_b=0, alu_ctrl=0, rsp_result=0, rsp_flags=0, rsp0/1_valid=0, owner=0, last_grant=1 (so requester 0 wins the first tie), busy=0.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Winner is the requester with valid set; if both, the one not equal to last_grant.
  - reqN_ready is combinational, =1 only for the winner in IDLE; all other readies are 0.
  - On the handshake edge: capture reqN_a/b/ctrl into alu_a/alu_b/alu_ctrl, owner=N, last_grant=N, go to EXEC.
  - No valid: stay IDLE, registers hold.
- EXEC (exactly 1 cycle): ALU settles on the registered operands. At the clock edge, capture alu_out->rsp_result and alu_flags->rsp_flags, set rsp<owner>_valid=1, go to RESP.
- RESP:
  - rsp<owner>_valid holds; rsp_result/rsp_flags stable.
  - On rsp<owner>_ready=1: clear valid, go to IDLE.
  - rspN_ready of the non-owner is ignored.
  - No new request is accepted in RESP.
- Latency: accept edge -> rsp_valid high 2 edges later. Minimum issue interval 3 cycles with rsp_ready tied high.
- Requester rules: reqN_valid, operands and ctrl stay stable until ready. Dropping valid before ready is legal and simply cancels; no grant occurs.
- Opcodes are passed through unmodified; undefined codes yield whatever the ALU returns (0, flags 1000).
- Only one rspN_valid is ever high. Both valids are never high in the same cycle as any reqN_ready.
- rst_n low in any state returns to IDLE immediately. An in-flight op is discarded with no response.

Optional Feature:
ALU_ARB_PERF_EN
- Defined: adds outputs perf_grant0, perf_grant1 (16-bit, +1 per accepted request of that requester) and perf_stall (16-bit, +1 per cycle where some reqN_valid=1 and reqN_ready=0).
- All three counters saturate at 0xFFFF and reset to 0.
- Not defined: ports and logic absent; core behaviour identical.

Test Plan:
- req0 ADD (ctrl 0000) a=5, b=3, rsp0_ready=1 -> req0_ready at cycle 0; rsp0_valid at cycle 2 with rsp_result=8, rsp_flags=4'b0000; back in IDLE at cycle 3.
- req1 SUB (0001) a=3, b=5 -> rsp1_valid, rsp_result=0xFFFFFFFE, rsp_flags=4'b0110.
- Both valid continuously, req0 ADD 0x7FFFFFFF+1 and req1 AND 0xF0F0+0x0FF0 -> grant order 0,1,0,1:
  - req0 result 0x80000000, flags 0101.
  - req1 result 0x00F0, flags 0000.
- Backpressure: rsp0_ready=0 for 5 cycles after rsp0_valid -> valid, result and flags stable, req1_valid=1 gets no ready, busy=1. On rsp0_ready=1 -> IDLE, req1 granted next cycle.
- rst_n pulsed low during EXEC -> all outputs at reset values immediately, no rsp valid after release. First tie after release goes to requester 0.
- With ALU_ARB_PERF_EN: 3 req0 ops plus 2 req1 ops issued with both valid -> perf_grant0=3, perf_grant1=2, perf_stall equals the counted cycles with an unserved valid. Counters preloaded to 0xFFFF stay at 0xFFFF.
